fft_frame_streamer: RTL and testbench

FFT_FRAME_STREAMER -- requirements
Module: fft_frame_streamer

---
 rtl/fft_pipe_pkg.sv | 29 ++
 rtl/fft_frame_buf.sv | 32 +++
 rtl/fft_frame_streamer.sv | 164 ++++++++++++++++
 tb/tb_fft_frame_streamer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pipe_pkg.sv
// Shared definitions for the FFT output streaming path.
// Holds the default word width and frame depth, the frame FSM state encoding
// and a bit-reverse helper used to compute the bit-reversed drain order.
package fft_pipe_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StDrain = 2'd2
  } state_e;

  // Reverse the low 'bits' bits of val; bits above are returned as zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] val, input int unsigned bits);
    logic [31:0] res;
    logic [4:0]  src;
    res = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < bits) begin
        src         = 5'(bits - 1 - i);
        res[i[4:0]] = val[src];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// Frame storage: DEPTH words of {real, imag}, synchronous write, combinational read.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data {real, imag}
//   raddr - read address
//   rdata - read data {real, imag}, combinational from raddr
module fft_frame_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [2*WIDTH-1:0]   wdata,
  input  logic [AW-1:0]        raddr,
  output logic [2*WIDTH-1:0]   rdata
);

  logic [2*WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_frame_streamer.sv
// Captures one frame of DEPTH complex FFT results and streams it out with a
// valid/ready handshake, in natural or bit-reversed order.
// Ports:
//   clk, reset               - clock and synchronous active-high reset
//   start                    - begin capturing a frame (accepted only when idle)
//   in_real, in_imag         - incoming word, qualified by in_valid
//   in_valid / in_ready      - input handshake; in_ready high only while filling
//   I, Q                     - registered output sample
//   out_valid / out_ready    - output handshake
//   out_index                - buffer address of the presented sample
//   out_first / out_last     - first / last sample of the frame
//   busy                     - frame in progress (fill or drain)
//   done                     - one-cycle pulse after the last output transfer
module fft_frame_streamer
  import fft_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned BITREV = 0,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_real,
  input  logic [WIDTH-1:0] in_imag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_index,
  output logic             out_first,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] Last = AW'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]      rd_cnt_q, rd_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   i_q, q_q;
  logic [AW-1:0]      idx_q;
  logic               first_q, last_q;

  logic               buf_we;
  logic               load;       // present buffer word at next_rd on this edge
  logic [AW-1:0]      next_rd;
  logic [AW-1:0]      rd_addr;
  logic [31:0]        rev_full;
  logic [2*WIDTH-1:0] rdata;

  fft_frame_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_cnt_q),
    .wdata ({in_real, in_imag}),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    buf_we      = 1'b0;
    load        = 1'b0;
    next_rd     = rd_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StFill;
          wr_cnt_d = '0;
        end
      end
      StFill: begin
        if (in_valid) begin
          buf_we = 1'b1;
          if (wr_cnt_q == Last) begin
            // Word 0 was written on an earlier cycle, so it can be presented now.
            state_d     = StDrain;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            next_rd     = '0;
            load        = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      StDrain: begin
        if (out_valid_q && out_ready) begin
          if (rd_cnt_q == Last) begin
            state_d     = StIdle;
            rd_cnt_d    = '0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q + AW'(1);
            next_rd  = rd_cnt_q + AW'(1);
            load     = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rev_full = bit_rev(32'(next_rd), AW);
  assign rd_addr  = (BITREV != 0) ? rev_full[AW-1:0] : next_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      i_q         <= '0;
      q_q         <= '0;
      idx_q       <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      if (load) begin
        i_q     <= rdata[2*WIDTH-1:WIDTH];
        q_q     <= rdata[WIDTH-1:0];
        idx_q   <= rd_addr;
        first_q <= (next_rd == '0);
        last_q  <= (next_rd == Last);
      end else if (done_d) begin
        first_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign in_ready  = (state_q == StFill);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign I         = i_q;
  assign Q         = q_q;
  assign out_index = idx_q;
  assign out_first = first_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Bench for fft_frame_streamer: two instances (natural and bit-reversed order)
// share one stimulus and are checked every cycle against a frame-level model.
module tb_fft_frame_streamer;

  localparam int W = 32;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         reset, start, in_valid, out_ready;
  logic [W-1:0] in_real, in_imag;

  logic         in_ready  [2];
  logic [W-1:0] i_o       [2];
  logic [W-1:0] q_o       [2];
  logic         out_valid [2];
  logic [4:0]   out_index [2];
  logic         out_first [2];
  logic         out_last  [2];
  logic         busy      [2];
  logic         done      [2];

  always #5 clk = ~clk;

  fft_frame_streamer #(.WIDTH(W), .DEPTH(D), .BITREV(0)) u_nat (
    .clk(clk), .reset(reset), .start(start), .in_real(in_real), .in_imag(in_imag),
    .in_valid(in_valid), .in_ready(in_ready[0]), .I(i_o[0]), .Q(q_o[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_index(out_index[0]),
    .out_first(out_first[0]), .out_last(out_last[0]), .busy(busy[0]), .done(done[0])
  );

  fft_frame_streamer #(.WIDTH(W), .DEPTH(D), .BITREV(1)) u_rev (
    .clk(clk), .reset(reset), .start(start), .in_real(in_real), .in_imag(in_imag),
    .in_valid(in_valid), .in_ready(in_ready[1]), .I(i_o[1]), .Q(q_o[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_index(out_index[1]),
    .out_first(out_first[1]), .out_last(out_last[1]), .busy(busy[1]), .done(done[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level model: mode 0 idle, 1 filling, 2 draining.
  int          m_mode = 0;
  logic [31:0] fq_re[$];
  logic [31:0] fq_im[$];
  logic [31:0] fr_re[D];
  logic [31:0] fr_im[D];
  int          m_pos  = 0;
  bit          m_done = 0;
  bit          m_zero = 1;   // outputs still hold their reset values

  bit          rec_en = 0;
  int          xfer_cnt = 0;
  logic [31:0] rec_i[$];
  int          rec_idx[$];

  function automatic int rev5(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++) if ((k >> b) & 1) r = r | (1 << (4 - b));
    return r;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got 0x%08h expected 0x%08h", name, d, $time, act, exp);
    end
  endtask

  // Compare process: outputs sampled 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      int idx;
      chk("busy", d, 32'(busy[d]), 32'(m_mode != 0));
      chk("in_ready", d, 32'(in_ready[d]), 32'(m_mode == 1));
      chk("done", d, 32'(done[d]), 32'(m_done));
      chk("out_valid", d, 32'(out_valid[d]), 32'(m_mode == 2));
      if (m_mode == 2) begin
        idx = (d == 0) ? m_pos : rev5(m_pos);
        chk("out_index", d, 32'(out_index[d]), 32'(idx));
        chk("I", d, i_o[d], fr_re[idx]);
        chk("Q", d, q_o[d], fr_im[idx]);
        chk("out_first", d, 32'(out_first[d]), 32'(m_pos == 0));
        chk("out_last", d, 32'(out_last[d]), 32'(m_pos == D - 1));
      end
      if (m_zero) begin
        chk("rst_I", d, i_o[d], 32'd0);
        chk("rst_Q", d, q_o[d], 32'd0);
        chk("rst_index", d, 32'(out_index[d]), 32'd0);
        chk("rst_first", d, 32'(out_first[d]), 32'd0);
        chk("rst_last", d, 32'(out_last[d]), 32'd0);
      end
    end
    if (out_valid[0] && out_ready) begin
      xfer_cnt++;
      if (rec_en) begin
        rec_i.push_back(i_o[0]);
        rec_idx.push_back(int'(out_index[1]));
      end
    end
  end

  task automatic model_edge(input bit rst, input bit st, input bit iv,
                            input logic [31:0] re, input logic [31:0] im, input bit ordy);
    if (rst) begin
      m_mode = 0; m_done = 0; m_zero = 1; m_pos = 0;
      fq_re.delete(); fq_im.delete();
    end else begin
      m_done = 0;
      case (m_mode)
        0: if (st) begin m_mode = 1; fq_re.delete(); fq_im.delete(); end
        1: if (iv) begin
          fq_re.push_back(re);
          fq_im.push_back(im);
          if (fq_re.size() == D) begin
            for (int k = 0; k < D; k++) begin fr_re[k] = fq_re[k]; fr_im[k] = fq_im[k]; end
            fq_re.delete(); fq_im.delete();
            m_mode = 2; m_pos = 0; m_zero = 0;
          end
        end
        default: if (ordy) begin
          if (m_pos == D - 1) begin m_mode = 0; m_done = 1; end
          else m_pos++;
        end
      endcase
    end
  endtask

  // Drive inputs for the next rising edge, advance the model, wait one cycle.
  task automatic step(input bit st, input bit iv, input logic [31:0] re,
                      input logic [31:0] im, input bit ordy, input bit rst);
    reset = rst; start = st; in_valid = iv; in_real = re; in_imag = im; out_ready = ordy;
    model_edge(rst, st, iv, re, im, ordy);
    @(negedge clk);
  endtask

  task automatic fill_frame(input int kind, input int vprob, input bit junk,
                            input int maxw, input bit do_start);
    int n = 0;
    if (do_start) step(1'b1, 1'b0, $urandom, $urandom, 1'($urandom_range(1)), 1'b0);
    while (m_mode == 1 && fq_re.size() < maxw && n < 2000) begin
      bit          v;
      int          k;
      logic [31:0] re, im;
      v = ($urandom_range(99) < vprob);
      k = fq_re.size();
      case (kind)
        0:       begin re = 32'(k);         im = 32'(-k); end
        1:       begin re = 32'(32'h100 + k); im = ~re;   end
        default: begin re = $urandom;       im = $urandom; end
      endcase
      if (!v) begin re = $urandom; im = $urandom; end
      step(junk && ($urandom_range(3) == 0), v, re, im, 1'($urandom_range(1)), 1'b0);
      n++;
    end
    if (n >= 2000) begin
      n_cmp++; n_err++;
      $display("FAIL fill_timeout: got %0d cycles required < 2000", n);
    end
  endtask

  task automatic drain_frame(input int rprob, input bit stallpat, input bit junk);
    int t = 0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (m_mode == 2 && t < 3000) begin
      bit r;
      r = stallpat ? pat[t % 4] : ($urandom_range(99) < rprob);
      step(junk ? 1'($urandom_range(1)) : 1'b0, junk ? 1'($urandom_range(1)) : 1'b0,
           $urandom, $urandom, r, 1'b0);
      t++;
    end
    if (t >= 3000) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d cycles required < 3000", t);
    end
  endtask

  initial begin
    int pins[5] = '{0, 16, 8, 24, 4};
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_real = '0; in_imag = '0;

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1, 0);

    // Frame k / -k, always ready; record both drain orders.
    rec_en = 1; rec_i.delete(); rec_idx.delete();
    fill_frame(0, 100, 0, D, 1);
    drain_frame(100, 0, 0);
    rec_en = 0;
    chk("seqA_len", 0, 32'(rec_i.size()), 32'(D));
    if (rec_i.size() == D) begin
      for (int i = 0; i < D; i++) chk("seqA_I", 0, rec_i[i], 32'(i));
      for (int i = 0; i < 5; i++) chk("seqA_revidx", 1, 32'(rec_idx[i]), 32'(pins[i]));
      chk("seqA_revidx_last", 1, 32'(rec_idx[D-1]), 32'(31));
    end
    repeat (2) step(0, 0, 0, 0, 1, 0);

    // Stall pattern 1,0,0,1 during drain.
    xfer_cnt = 0;
    fill_frame(0, 100, 0, D, 1);
    drain_frame(0, 1, 0);
    chk("stall_xfers", 0, 32'(xfer_cnt), 32'(D));
    repeat (2) step(0, 0, 0, 0, 1, 0);

    // Ignored start / in_valid outside FILL.
    repeat (4) step(0, 1, $urandom, $urandom, 1, 0);
    fill_frame(0, 70, 1, D, 1);
    drain_frame(60, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1, 0);

    // Reset after 10 fill writes, then a clean frame of 0x100+k.
    fill_frame(0, 100, 0, 10, 1);
    step(0, 1, $urandom, $urandom, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    rec_en = 1; rec_i.delete(); rec_idx.delete();
    fill_frame(1, 100, 0, D, 1);
    drain_frame(100, 0, 0);
    rec_en = 0;
    chk("seqR_len", 0, 32'(rec_i.size()), 32'(D));
    if (rec_i.size() == D)
      for (int i = 0; i < D; i++) chk("seqR_I", 0, rec_i[i], 32'(32'h100 + i));

    // Back-to-back frames: start in the done cycle.
    chk("gap_done", 0, 32'(done[0]), 32'd1);
    chk("gap_busy", 0, 32'(busy[0]), 32'd0);
    step(1, 0, 0, 0, 1, 0);
    chk("gap_busy_end", 0, 32'(busy[0]), 32'd1);
    fill_frame(2, 100, 0, D, 0);
    drain_frame(100, 0, 0);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      int gap = $urandom_range(3);
      for (int g = 0; g < gap; g++)
        step(0, 1'($urandom_range(1)), $urandom, $urandom, 1'($urandom_range(1)), 0);
      fill_frame(2, 40 + $urandom_range(60), 1, D, 1);
      drain_frame(30 + $urandom_range(70), 0, 1);
    end
    repeat (3) step(0, 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
